// File: rtl/hamming_tx_serializer_pkg.sv
// Shared definitions for the Hamming(7,4) transmit and receive blocks: FSM states,
// the encoder and the Hamming-position to codeword-bit mapping.
package hamming_tx_serializer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } tx_state_t;

    localparam logic [2:0] LAST_DATA_IDX = 3'd6;

    // x[3]=x0 .. x[0]=x3; result is {p0,p1,x0,p2,x1,x2,x3}
    function automatic logic [6:0] hamming74_encode(input logic [3:0] x);
        logic x0, x1, x2, x3;
        x0 = x[3];
        x1 = x[2];
        x2 = x[1];
        x3 = x[0];
        return {x0 ^ x1 ^ x3, x0 ^ x2 ^ x3, x0, x1 ^ x2 ^ x3, x1, x2, x3};
    endfunction

    // Hamming position 1..7 maps to codeword bit 6..0; position 0 is never flipped.
    function automatic logic [2:0] pos_to_bit(input logic [2:0] pos);
        return 3'd7 - pos;
    endfunction

    function automatic logic [6:0] error_mask(input logic en, input logic [2:0] pos);
        logic [6:0] mask;
        mask = '0;
        if (en && (pos != 3'd0)) begin
            mask = 7'b1 << pos_to_bit(pos);
        end
        return mask;
    endfunction

endpackage

// File: rtl/hamming_tx_serializer_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter and a one-cycle pulse
// on each accepted rising edge of the debounced level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          stable_q;
    logic [CW-1:0] cnt_q;
    logic          accept;

    // The synchronized level must differ from the accepted one for DEBOUNCE_CYCLES edges.
    assign accept = (sync_q[1] != stable_q) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= 2'b00;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            pulse    <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn};
            pulse  <= accept && sync_q[1];
            if (sync_q[1] == stable_q) begin
                cnt_q <= '0;
            end else if (accept) begin
                stable_q <= sync_q[1];
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hamming_tx_serializer.sv
// Latches DIP data on a debounced press, Hamming(7,4)-encodes it with optional
// single-bit error injection and shifts the frame out as start + 7 data + stop.
module hamming_tx_serializer
    import hamming_tx_serializer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int BIT_CYCLES      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] Push_button,
    input  logic [7:0] DIP_switch,
    output logic [6:0] codeword,
    output logic       tx_serial,
    output logic       tx_busy,
    output logic       frame_done,
    output logic [9:0] LEDs
);
    localparam int TW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(BIT_CYCLES - 1);

    tx_state_t     state_q, state_n;
    logic [TW-1:0] timer_q, timer_n;
    logic [2:0]    idx_q, idx_n;
    logic [6:0]    cw_q;
    logic          err_q;
    logic          ser_q, ser_n;
    logic          busy_q;
    logic          done_q, done_n;
    logic          led_ser_q;
    logic          send;
    logic          bit_end;
    logic          unused_btn;

    assign unused_btn = Push_button[1];

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .btn   (Push_button[0]),
        .pulse (send)
    );

    assign bit_end = (timer_q == T_LAST);

    always_comb begin
        state_n = state_q;
        timer_n = timer_q;
        idx_n   = idx_q;
        done_n  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (send) state_n = ST_LOAD;
            end
            ST_LOAD: begin
                state_n = ST_START;
                timer_n = '0;
                idx_n   = '0;
            end
            ST_START: begin
                if (bit_end) begin
                    timer_n = '0;
                    idx_n   = '0;
                    state_n = ST_DATA;
                end else begin
                    timer_n = timer_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    timer_n = '0;
                    if (idx_q == LAST_DATA_IDX) state_n = ST_STOP;
                    else                        idx_n   = idx_q + 3'd1;
                end else begin
                    timer_n = timer_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    timer_n = '0;
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end else begin
                    timer_n = timer_q + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Line level is computed from the next state so the registered output lines up with it.
        unique case (state_n)
            ST_START: ser_n = 1'b0;
            ST_DATA:  ser_n = cw_q[3'd6 - idx_n];
            default:  ser_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            idx_q     <= '0;
            cw_q      <= '0;
            err_q     <= 1'b0;
            ser_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            led_ser_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            timer_q   <= timer_n;
            idx_q     <= idx_n;
            ser_q     <= ser_n;
            busy_q    <= (state_n != ST_IDLE);
            done_q    <= done_n;
            led_ser_q <= ser_n;
            if (state_q == ST_LOAD) begin
                cw_q  <= hamming74_encode(DIP_switch[3:0]) ^ error_mask(DIP_switch[7], DIP_switch[6:4]);
                err_q <= DIP_switch[7] && (DIP_switch[6:4] != 3'd0);
            end
        end
    end

    assign codeword   = cw_q;
    assign tx_serial  = ser_q;
    assign tx_busy    = busy_q;
    assign frame_done = done_q;
    // LED 9 has its own flop so the whole LED bank reads zero while in reset.
    assign LEDs       = {led_ser_q, err_q, busy_q, cw_q};

endmodule

// File: tb/tb_hamming_tx_serializer.sv
// Bench for hamming_tx_serializer: table vectors, random data against a
// Hamming-position reference model, and hand-written press/reset sequences.
module tb_hamming_tx_serializer;
    localparam int DEB  = 4;
    localparam int BITC = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] Push_button;
    logic [7:0] DIP_switch;
    logic [6:0] codeword;
    logic       tx_serial;
    logic       tx_busy;
    logic       frame_done;
    logic [9:0] LEDs;

    int errors = 0;
    int checks = 0;
    int fd_count = 0;
    int led_bad = 0;
    logic cap_q[$];
    logic exp_q[$];

    typedef struct {
        logic [7:0] dip;
        logic [6:0] cw;
        logic       err;
    } vec_t;
    vec_t vecs[8];

    hamming_tx_serializer #(
        .DEBOUNCE_CYCLES(DEB),
        .BIT_CYCLES     (BITC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Push_button (Push_button),
        .DIP_switch  (DIP_switch),
        .codeword    (codeword),
        .tx_serial   (tx_serial),
        .tx_busy     (tx_busy),
        .frame_done  (frame_done),
        .LEDs        (LEDs)
    );

    always #5 clk = ~clk;

    // Monitor: counts frame_done cycles, records the line while busy, tracks LED mirroring.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (frame_done) fd_count++;
            if (tx_busy) cap_q.push_back(tx_serial);
            if (LEDs[9] !== tx_serial || LEDs[7] !== tx_busy || LEDs[6:0] !== codeword) led_bad++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: place data at Hamming positions 3,5,6,7; parity at 2^k covers positions with bit k set.
    function automatic void model(input logic [7:0] dip, output logic [6:0] cw, output logic err);
        logic [7:1] h;
        logic [2:0] pos;
        logic       par;
        h    = '0;
        h[3] = dip[3];
        h[5] = dip[2];
        h[6] = dip[1];
        h[7] = dip[0];
        for (int k = 0; k < 3; k++) begin
            par = 1'b0;
            for (int p = 1; p <= 7; p++) begin
                if (((p >> k) & 1) == 1 && p != (1 << k)) par = par ^ h[p];
            end
            h[1 << k] = par;
        end
        pos = dip[6:4];
        err = dip[7] && (pos != 3'd0);
        if (err) h[pos] = ~h[pos];
        for (int p = 1; p <= 7; p++) cw[7 - p] = h[p];
    endfunction

    task automatic build_exp(input logic [6:0] cw);
        exp_q.delete();
        exp_q.push_back(1'b1);
        repeat (BITC) exp_q.push_back(1'b0);
        for (int i = 6; i >= 0; i--) repeat (BITC) exp_q.push_back(cw[i]);
        repeat (BITC) exp_q.push_back(1'b1);
    endtask

    task automatic compare_frame(input int cb, input logic [6:0] cw, input string name);
        logic [31:0] got_bits;
        logic [31:0] exp_bits;
        int          got_len;
        build_exp(cw);
        got_bits = '0;
        exp_bits = '0;
        got_len  = cap_q.size() - cb;
        for (int i = cb; i < cap_q.size(); i++) got_bits = {got_bits[30:0], cap_q[i]};
        for (int i = 0; i < exp_q.size(); i++) exp_bits = {exp_bits[30:0], exp_q[i]};
        checks++;
        if (got_len != exp_q.size() || got_bits !== exp_bits) begin
            errors++;
            $display("FAIL %s frame: got len %0d bits %b expected len %0d bits %b",
                     name, got_len, got_bits, exp_q.size(), exp_bits);
        end
    endtask

    task automatic press(input int n);
        Push_button[0] = 1'b1;
        tick(n);
        Push_button[0] = 1'b0;
    endtask

    task automatic wait_busy(input string name);
        int t;
        t = 0;
        while (!tx_busy && t < 100) begin
            tick();
            t++;
        end
        if (!tx_busy) begin
            checks++;
            errors++;
            $display("FAIL %s busy timeout: got busy=0 expected busy=1 within 100 cycles", name);
        end
    endtask

    task automatic wait_done(input int base, input string name);
        int t;
        t = 0;
        while (fd_count - base < 1 && t < 300) begin
            tick();
            t++;
        end
        if (fd_count - base < 1) begin
            checks++;
            errors++;
            $display("FAIL %s done timeout: got 0 frame_done expected 1 within 300 cycles", name);
        end
        tick(4);
    endtask

    task automatic run_frame(input logic [7:0] dip, input logic [6:0] exp_cw, input logic exp_err,
                             input string name);
        int fb;
        int cb;
        DIP_switch = dip;
        fb = fd_count;
        cb = cap_q.size();
        press(10);
        wait_done(fb, name);
        tick(10);
        check({name, " codeword"}, codeword, exp_cw);
        check({name, " led_cw"}, LEDs[6:0], exp_cw);
        check({name, " led_err"}, LEDs[8], exp_err);
        check({name, " done_count"}, fd_count - fb, 1);
        compare_frame(cb, exp_cw, name);
    endtask

    initial begin : main
        logic [6:0] m_cw;
        logic       m_err;
        logic [7:0] dip;
        int         fb;
        int         cb;

        vecs[0] = '{8'h0B, 7'b0110011, 1'b0};
        vecs[1] = '{8'hDB, 7'b0110111, 1'b1};
        vecs[2] = '{8'h8F, 7'b1111111, 1'b0};
        vecs[3] = '{8'h9F, 7'b0111111, 1'b1};
        vecs[4] = '{8'h00, 7'b0000000, 1'b0};
        vecs[5] = '{8'hF0, 7'b0000001, 1'b1};
        vecs[6] = '{8'hB8, 7'b1100000, 1'b1};
        vecs[7] = '{8'h71, 7'b1101001, 1'b0};

        rst         = 1'b1;
        Push_button = 2'b00;
        DIP_switch  = 8'h00;
        tick(3);
        check("reset tx_serial", tx_serial, 1);
        check("reset tx_busy", tx_busy, 0);
        check("reset frame_done", frame_done, 0);
        check("reset codeword", codeword, 0);
        check("reset LEDs", LEDs, 0);
        rst = 1'b0;
        tick(3);
        check("idle LEDs", LEDs, 10'h200);

        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i].dip, vecs[i].cw, vecs[i].err, $sformatf("vec%0d", i));
        end

        repeat (12) begin
            dip = 8'($urandom_range(0, 255));
            model(dip, m_cw, m_err);
            run_frame(dip, m_cw, m_err, $sformatf("rand_%02h", dip));
        end

        // Short glitches never reach the debounce threshold.
        DIP_switch = 8'h0B;
        fb = fd_count;
        cb = cap_q.size();
        repeat (3) begin
            Push_button[0] = 1'b1;
            tick(3);
            Push_button[0] = 1'b0;
            tick(3);
        end
        tick(30);
        check("glitch done_count", fd_count - fb, 0);
        check("glitch busy_samples", cap_q.size() - cb, 0);

        // A long hold produces exactly one frame.
        fb = fd_count;
        cb = cap_q.size();
        press(50);
        tick(40);
        check("hold done_count", fd_count - fb, 1);
        compare_frame(cb, 7'b0110011, "hold");

        // Second press and DIP change while a frame is in flight.
        DIP_switch = 8'h0B;
        fb = fd_count;
        cb = cap_q.size();
        Push_button[0] = 1'b1;
        wait_busy("midframe");
        tick(1);
        Push_button[0] = 1'b0;
        DIP_switch = 8'h5C;
        tick(8);
        press(8);
        DIP_switch = 8'hFF;
        wait_done(fb, "midframe");
        tick(30);
        check("midframe done_count", fd_count - fb, 1);
        check("midframe codeword", codeword, 7'b0110011);
        compare_frame(cb, 7'b0110011, "midframe");

        // Asynchronous reset in the middle of the data bits.
        DIP_switch = 8'h8F;
        Push_button[0] = 1'b1;
        wait_busy("rst_mid");
        Push_button[0] = 1'b0;
        tick(5);
        check("pre_rst busy", tx_busy, 1);
        rst = 1'b1;
        #1;
        check("rst_mid tx_serial", tx_serial, 1);
        check("rst_mid tx_busy", tx_busy, 0);
        check("rst_mid codeword", codeword, 0);
        check("rst_mid LEDs", LEDs, 0);
        check("rst_mid frame_done", frame_done, 0);
        tick(2);
        rst = 1'b0;
        tick(10);
        run_frame(8'h0B, 7'b0110011, 1'b0, "post_rst");

        check("led_mirror", led_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
